// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_port_arbiter                                          |
// | Description : Round-robin arbiter sharing one data-memory port between   |
// |               the MEM stages of NUM_CORES pipelines. Each access is      |
// |               latched at grant, held until mem_ack, then completed with  |
// |               a one-cycle core_done pulse.                               |
// | Options     : ARB_TIMEOUT_EN - adds a BUSY watchdog that abandons an     |
// |               unacknowledged access after TIMEOUT_CYCLES and pulses      |
// |               arb_err.                                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_port_arbiter #(
   parameter int NUM_CORES      = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_stall,
   output logic [NUM_CORES-1:0]        core_done,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic                        mem_ack,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        arb_err
);

   localparam int GW = $clog2(NUM_CORES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_grant_q, last_grant_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]      core_rdata_q, core_rdata_d;
   logic [NUM_CORES-1:0]   core_done_q, core_done_d;

   logic [ADDR_W-1:0]      addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]      wdata_arr [NUM_CORES];
   logic [GW-1:0]          cand;
   logic [GW-1:0]          pick;
   logic                   found;

   // Reject configurations outside the supported range at elaboration time.
   generate
      if (NUM_CORES < 2 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
         $error("dmem_port_arbiter: parameter out of range");
      end
   endgenerate

   // Split the packed per-core buses into arrays for indexed selection.
   generate
      for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
         assign addr_arr[i]  = core_addr[i*ADDR_W +: ADDR_W];
         assign wdata_arr[i] = core_wdata[i*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          arb_err_q, arb_err_d;
`endif

   // Round-robin search: first requester after the previous winner, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = last_grant_q;
      cand  = last_grant_q;
      for (int k = 1; k <= NUM_CORES; k++) begin
         cand = GW'((int'(last_grant_q) + k) % NUM_CORES);
         if (!found && core_req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and registered-output logic for the grant/busy/response sequence.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      core_rdata_d = core_rdata_q;
      core_done_d  = '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      arb_err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = pick;
               last_grant_d = pick;
               mem_we_d     = core_we[pick];
               mem_addr_d   = addr_arr[pick];
               mem_wdata_d  = wdata_arr[pick];
               mem_req_d    = 1'b1;
               state_d      = BUSY;
`ifdef ARB_TIMEOUT_EN
               tmo_cnt_d    = '0;
`endif
            end
         end
         BUSY: begin
            if (mem_ack) begin
               mem_req_d            = 1'b0;
               core_done_d[grant_q] = 1'b1;
               state_d              = RESP;
               if (!mem_we_q) begin
                  core_rdata_d = mem_rdata;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               // Abandon the access so the requesting core is released.
               mem_req_d            = 1'b0;
               core_done_d[grant_q] = 1'b1;
               core_rdata_d         = '0;
               arb_err_d            = 1'b1;
               state_d              = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset makes core 0 the first winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_CORES - 1);
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         core_done_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_rdata_q <= core_rdata_d;
         core_done_q  <= core_done_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Watchdog counter and error pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         arb_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         arb_err_q <= arb_err_d;
      end
   end

   assign arb_err = arb_err_q;
`else
   assign arb_err = 1'b0;
`endif

   assign core_stall = core_req & ~core_done_q;
   assign core_done  = core_done_q;
   assign core_rdata = core_rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_port_arbiter                                       |
// | Description : Self-checking bench for dmem_port_arbiter: directed cases  |
// |               followed by randomized cores and memory, compared against  |
// |               a transaction-level round-robin model.                     |
// | Options     : ARB_TIMEOUT_EN - also exercises the watchdog path.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dmem_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   localparam int P_FREE = 0;
   localparam int P_BUSY = 1;
   localparam int P_RESP = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    core_req, core_we, core_stall, core_done;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_wdata;
   logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_req, mem_we, mem_ack, arb_err;

   logic            req_a [N];
   logic            we_a  [N];
   logic [AW-1:0]   a_arr [N];
   logic [DW-1:0]   d_arr [N];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int            phase, last_win, win, to_cnt, delay;
   logic          exp_we, exp_err;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_rdata;
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   int            dut_grants [$];

   dmem_port_arbiter #(
      .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .arb_err(arb_err)
   );

   generate
      for (genvar i = 0; i < N; i++) begin : g_pack
         assign core_req[i]             = req_a[i];
         assign core_we[i]              = we_a[i];
         assign core_addr[i*AW +: AW]   = a_arr[i];
         assign core_wdata[i*DW +: DW]  = d_arr[i];
      end
   endgenerate

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (((req >> c) & N'(1)) != '0) return c;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Advance the model by one clock using the inputs the DUT just sampled, then compare.
   task automatic observe();
      logic [N-1:0] exp_done;
      exp_done = '0;
      exp_err  = 1'b0;
      case (phase)
         P_FREE: begin
            win = rr_pick(core_req, last_win);
            if (win >= 0) begin
               last_win  = win;
               phase     = P_BUSY;
               to_cnt    = 0;
               exp_we    = we_a[win];
               exp_addr  = a_arr[win];
               exp_wdata = d_arr[win];
               delay     = $urandom_range(0, 4);
            end
         end
         P_BUSY: begin
            if (mem_ack) begin
               phase         = P_RESP;
               exp_done[win] = 1'b1;
               if (exp_we) mem_model[exp_addr] = exp_wdata;
               else        exp_rdata = mem_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               to_cnt++;
               if (to_cnt == TO) begin
                  phase         = P_RESP;
                  exp_done[win] = 1'b1;
                  exp_err       = 1'b1;
                  exp_rdata     = '0;
               end
            end
`endif
         end
         default: phase = P_FREE;
      endcase
      for (int c = 0; c < N; c++) if (core_done[c]) dut_grants.push_back(c);
      check_eq("mem_req", mem_req, phase == P_BUSY);
      check_eq("core_done", core_done, exp_done);
      check_eq("core_rdata", core_rdata, exp_rdata);
      check_eq("arb_err", arb_err, exp_err);
      if (phase == P_BUSY) begin
         check_eq("mem_addr", mem_addr, exp_addr);
         check_eq("mem_we", mem_we, exp_we);
         check_eq("mem_wdata", mem_wdata, exp_wdata);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!rst) observe();
   endtask

   // Memory responder: random ack latency while busy, spurious acks otherwise.
   task automatic drive_mem();
      if (phase == P_BUSY) begin
         if (delay == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = exp_we ? DW'($urandom) : mem_lookup(exp_addr);
         end else begin
            delay--;
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
         end
      end else begin
         mem_ack   = ($urandom_range(0, 3) == 0);
         mem_rdata = DW'($urandom);
      end
   endtask

   task automatic new_req(input int i, input logic on);
      req_a[i] = on;
      we_a[i]  = 1'($urandom_range(0, 1));
      a_arr[i] = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      d_arr[i] = DW'($urandom);
   endtask

   // Pipeline-like cores: advance on done, otherwise hold with occasional noise.
   task automatic drive_cores();
      for (int i = 0; i < N; i++) begin
         if (phase == P_RESP && i == win) begin
            new_req(i, $urandom_range(0, 2) != 0);
         end else if (req_a[i]) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) req_a[i] = 1'b0;
            else if (r < 4) begin
               a_arr[i] = DW'($urandom);
               d_arr[i] = DW'($urandom);
               we_a[i]  = ~we_a[i];
            end
         end else if ($urandom_range(0, 2) == 0) begin
            new_req(i, 1'b1);
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < N; k++) req_a[k] = 1'b0;
      for (int k = 0; k < 40 && phase != P_FREE; k++) begin
         step();
         drive_mem();
      end
      mem_ack = 1'b0;
      check_eq("drain_idle", mem_req, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < N; i++) begin
         req_a[i] = 1'b0; we_a[i] = 1'b0; a_arr[i] = '0; d_arr[i] = '0;
      end
      mem_ack = 1'b0; mem_rdata = '0;
      phase = P_FREE; last_win = N - 1; win = 0; exp_rdata = '0;
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_err = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_mem_addr", mem_addr, '0);
      check_eq("rst_mem_wdata", mem_wdata, '0);
      check_eq("rst_core_done", core_done, '0);
      check_eq("rst_core_rdata", core_rdata, '0);
      check_eq("rst_arb_err", arb_err, 1'b0);
      check_eq("rst_core_stall", core_stall, '0);
      rst = 1'b0;

      // Single read by core 0, ack in the first busy cycle
      req_a[0] = 1'b1; we_a[0] = 1'b0; a_arr[0] = 32'h100;
      #1 check_eq("t1_stall_c1", core_stall[0], 1'b1);
      step();
      check_eq("t1_mem_req", mem_req, 1'b1);
      check_eq("t1_mem_addr", mem_addr, 32'h100);
      check_eq("t1_stall_c2", core_stall[0], 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0;
      check_eq("t1_done", core_done, 3'b001);
      check_eq("t1_rdata", core_rdata, 32'hDEADBEEF);
      check_eq("t1_stall_done", core_stall[0], 1'b0);
      req_a[0] = 1'b0;

      // Cores 0 and 1 request continuously: grants must alternate
      req_a[0] = 1'b1; a_arr[0] = 32'h10; req_a[1] = 1'b1; a_arr[1] = 32'h20;
      dut_grants.delete();
      for (int k = 0; k < 40; k++) begin
         step();
         drive_mem();
      end
      check_eq("t2_grant_count", dut_grants.size() >= 6, 1'b1);
      for (int k = 1; k < dut_grants.size(); k++)
         check_eq("t2_alternate", dut_grants[k] != dut_grants[k-1], 1'b1);
      drain();

      // Core 1 store with a 5-cycle ack delay while its inputs keep changing
      req_a[1] = 1'b1; we_a[1] = 1'b1; a_arr[1] = 32'h200; d_arr[1] = 32'h12345678;
      dut_grants.delete();
      step();
      for (int k = 0; k < 5; k++) begin
         a_arr[1] = DW'($urandom); d_arr[1] = DW'($urandom); we_a[1] = 1'b0;
         check_eq("t3_mem_we", mem_we, 1'b1);
         check_eq("t3_mem_addr", mem_addr, 32'h200);
         check_eq("t3_mem_wdata", mem_wdata, 32'h12345678);
         step();
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check_eq("t3_done", core_done, 3'b010);
      req_a[1] = 1'b0;
      step();
      check_eq("t3_done_once", dut_grants.size(), 1);
      drain();

      // Core 0 drops its request in the second busy cycle
      req_a[0] = 1'b1; we_a[0] = 1'b0; a_arr[0] = 32'h300;
      step();
      step();
      req_a[0] = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_ack = 1'b0;
      check_eq("t4_done", core_done, 3'b001);
      check_eq("t4_rdata", core_rdata, 32'hCAFEF00D);
      drain();

      // Asynchronous reset during busy
      req_a[0] = 1'b1; we_a[0] = 1'b0; a_arr[0] = 32'h400;
      req_a[1] = 1'b1; we_a[1] = 1'b0; a_arr[1] = 32'h500;
      step();
      check_eq("t5_busy", mem_req, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("t5_async_mem_req", mem_req, 1'b0);
      check_eq("t5_async_done", core_done, '0);
      check_eq("t5_async_rdata", core_rdata, '0);
      phase = P_FREE; last_win = N - 1; exp_rdata = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check_eq("t5_first_grant", mem_addr, 32'h400);
      mem_ack = 1'b1; mem_rdata = DW'($urandom);
      step();
      mem_ack = 1'b0;
      drain();

`ifdef ARB_TIMEOUT_EN
      // Memory never acks: watchdog releases the core, then the next one is served
      req_a[0] = 1'b1; a_arr[0] = 32'h600; req_a[1] = 1'b1; a_arr[1] = 32'h700;
      mem_ack = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (core_done == '0 && n < 20);
      check_eq("to_latency", n, TO + 1);
      check_eq("to_err", arb_err, 1'b1);
      check_eq("to_rdata", core_rdata, '0);
      dut_grants.delete();
      for (int k = 0; k < 12; k++) begin
         step();
         drive_mem();
      end
      check_eq("to_next_served", dut_grants.size() > 0, 1'b1);
      drain();
`endif

      // Randomized traffic
      n = 0;
      for (int k = 0; k < 1500; k++) begin
         step();
         drive_mem();
         drive_cores();
         #1 check_eq("core_stall", core_stall, core_req & ~core_done);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
